sram_rw_port_ctrl: RTL and testbench

- Request/response front end that drives one single-port synchronous SRAM macro port: RW0 addr/en/wmode/wdata, with 1-cycle registered read data.
- Converts a valid/ready request channel into SRAM port cycles.
- Captures read data in the only cycle it is guaranteed valid.
- Returns in-order responses through a small buffer, and optionally zero-fills the array after reset before accepting traffic.

---
 rtl/sram_rw_port_ctrl_if.sv | 42 ++++
 rtl/sram_rw_port_ctrl.sv | 136 +++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response channel plus the RW0 port of one single-port SRAM macro.
// The master is the requester side that also models the macro.
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic              io_req_valid;
  logic              io_req_ready;
  logic              io_req_bits_write;
  logic [ADDR_W-1:0] io_req_bits_addr;
  logic [DATA_W-1:0] io_req_bits_wdata;
  logic              io_resp_valid;
  logic              io_resp_ready;
  logic              io_resp_bits_write;
  logic [DATA_W-1:0] io_resp_bits_rdata;
  logic              io_busy;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport master (
    output io_req_valid, io_req_bits_write,
    output io_req_bits_addr, io_req_bits_wdata,
    output io_resp_ready, RW0_rdata,
    input  io_req_ready, io_resp_valid,
    input  io_resp_bits_write, io_resp_bits_rdata,
    input  io_busy, RW0_addr, RW0_en,
    input  RW0_wmode, RW0_wdata
  );

  modport slave (
    input  io_req_valid, io_req_bits_write,
    input  io_req_bits_addr, io_req_bits_wdata,
    input  io_resp_ready, RW0_rdata,
    output io_req_ready, io_resp_valid,
    output io_resp_bits_write, io_resp_bits_rdata,
    output io_busy, RW0_addr, RW0_en,
    output RW0_wmode, RW0_wdata
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Valid/ready front end for a single-port SRAM with 1-cycle read data,
// in-order response buffer and optional zero-fill after reset.
module sram_rw_port_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16384,
  parameter int INIT_ZERO  = 1,
  parameter int RESP_DEPTH = 2
) (
  input logic clock,
  input logic reset,
  sram_rw_port_ctrl_if.slave bus
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_write_q, s1_write_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              fifo_wr_q [RESP_DEPTH];
  logic              fifo_wr_d [RESP_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [RESP_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [RESP_DEPTH];

  logic [CW:0]       occ;
  logic              fire;
  logic              busy;
  logic              empty;
  logic              push;
  logic              pop;
  logic              cap_write;
  logic [DATA_W-1:0] cap_data;

  function automatic logic [PW-1:0] inc_ptr(
    input logic [PW-1:0] p
  );
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_valid_d  = 1'b0;
    s1_write_d  = s1_write_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_data_d = fifo_data_q;

    occ   = {{CW{1'b0}}, s1_valid_q} + {1'b0, count_q};
    busy  = !reset && (state_q == S_INIT);
    bus.io_busy      = busy;
    bus.io_req_ready = !reset && (state_q == S_RUN)
                     && (occ < (CW+1)'(RESP_DEPTH));
    fire = bus.io_req_valid && bus.io_req_ready;

    bus.RW0_en    = fire;
    bus.RW0_wmode = bus.io_req_bits_write;
    bus.RW0_addr  = bus.io_req_bits_addr;
    bus.RW0_wdata = bus.io_req_bits_wdata;

    if (busy) begin
      bus.RW0_en    = 1'b1;
      bus.RW0_wmode = 1'b1;
      bus.RW0_addr  = cnt_q;
      bus.RW0_wdata = '0;
      cnt_d         = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = S_RUN;
      end
    end

    if (fire) begin
      s1_valid_d = 1'b1;
      s1_write_d = bus.io_req_bits_write;
    end

    // RW0_rdata is only trustworthy the cycle after the read enable
    cap_write = s1_write_q;
    cap_data  = s1_write_q ? '0 : bus.RW0_rdata;
    empty     = (count_q == '0);

    bus.io_resp_valid      = !reset && (!empty || s1_valid_q);
    bus.io_resp_bits_write = empty ? cap_write : fifo_wr_q[head_q];
    bus.io_resp_bits_rdata = empty ? cap_data : fifo_data_q[head_q];

    pop  = bus.io_resp_valid && bus.io_resp_ready && !empty;
    push = s1_valid_q && (!empty || !bus.io_resp_ready);

    if (push) begin
      fifo_wr_d[tail_q]   = cap_write;
      fifo_data_d[tail_q] = cap_data;
      tail_d              = inc_ptr(tail_q);
    end
    if (pop) begin
      head_d = inc_ptr(head_q);
    end
    unique case (1'b1)
      push && !pop: count_d = count_q + CW'(1);
      pop && !push: count_d = count_q - CW'(1);
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_write_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_write_q <= s1_write_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
    fifo_wr_q   <= fifo_wr_d;
    fifo_data_q <= fifo_data_d;
  end
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Bench for sram_rw_port_ctrl: SRAM macro model, directed scenarios
// and randomized traffic against an outstanding-response queue model.
module tb_sram_rw_port_ctrl;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 64;
  localparam int DEPTH      = 16;
  localparam int RESP_DEPTH = 2;

  typedef struct {
    logic              w;
    logic [DATA_W-1:0] d;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_rw_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_rw_port_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .INIT_ZERO(1),
    .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // SRAM macro: read data only valid the cycle after a read enable
  logic [DATA_W-1:0] sram [int];
  always @(posedge clock) begin
    if (bus.RW0_en && bus.RW0_wmode) begin
      sram[int'(bus.RW0_addr)] = bus.RW0_wdata;
    end
    if (bus.RW0_en && !bus.RW0_wmode) begin
      if (sram.exists(int'(bus.RW0_addr)))
        bus.RW0_rdata <= sram[int'(bus.RW0_addr)];
      else
        bus.RW0_rdata <= '0;
    end else begin
      bus.RW0_rdata <= {$urandom, $urandom};
    end
  end

  // Reference: words in the array plus the queue of owed responses
  logic [DATA_W-1:0] ref_mem [int];
  rsp_t exp_q [$];
  int   init_idx = 0;

  always @(negedge clock) begin
    rsp_t e;
    bit   rdy_m;
    bit   fire_m;
    int   a;
    if (reset) begin
      check("rst_en", bus.RW0_en, 0);
      check("rst_req_ready", bus.io_req_ready, 0);
      check("rst_resp_valid", bus.io_resp_valid, 0);
      check("rst_busy", bus.io_busy, 0);
      exp_q.delete();
      init_idx = 0;
    end else if (init_idx < DEPTH) begin
      check("init_busy", bus.io_busy, 1);
      check("init_en", bus.RW0_en, 1);
      check("init_wmode", bus.RW0_wmode, 1);
      check("init_wdata", bus.RW0_wdata, 0);
      check("init_addr", 64'(bus.RW0_addr), 64'(init_idx));
      check("init_req_ready", bus.io_req_ready, 0);
      check("init_resp_valid", bus.io_resp_valid, 0);
      ref_mem[init_idx] = '0;
      init_idx++;
    end else begin
      rdy_m  = exp_q.size() < RESP_DEPTH;
      fire_m = bus.io_req_valid && rdy_m;
      check("busy", bus.io_busy, 0);
      check("req_ready", bus.io_req_ready, rdy_m);
      check("resp_valid", bus.io_resp_valid, exp_q.size() != 0);
      if (bus.io_resp_valid && bus.io_resp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_write", bus.io_resp_bits_write, e.w);
        check("resp_rdata", bus.io_resp_bits_rdata, e.d);
      end
      check("rw0_en", bus.RW0_en, fire_m);
      if (fire_m) begin
        a = int'(bus.io_req_bits_addr);
        check("rw0_addr", 64'(bus.RW0_addr), 64'(a));
        check("rw0_wmode", bus.RW0_wmode, bus.io_req_bits_write);
        if (bus.io_req_bits_write) begin
          check("rw0_wdata", bus.RW0_wdata, bus.io_req_bits_wdata);
          ref_mem[a] = bus.io_req_bits_wdata;
          e.w = 1'b1;
          e.d = '0;
        end else begin
          e.w = 1'b0;
          e.d = ref_mem.exists(a) ? ref_mem[a] : '0;
        end
        exp_q.push_back(e);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(
    input bit w,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d
  );
    bit f = 1'b0;
    int n = 0;
    bus.io_req_valid      = 1'b1;
    bus.io_req_bits_write = w;
    bus.io_req_bits_addr  = a;
    bus.io_req_bits_wdata = d;
    while (!f && n < 64) begin
      @(negedge clock);
      f = bus.io_req_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!f) check("send_timeout", 64'(f), 1);
    bus.io_req_valid = 1'b0;
  endtask

  initial begin
    bus.io_req_valid      = 1'b0;
    bus.io_req_bits_write = 1'b0;
    bus.io_req_bits_addr  = '0;
    bus.io_req_bits_wdata = '0;
    bus.io_resp_ready     = 1'b1;
    for (int i = 0; i < DEPTH; i++) sram[i] = {$urandom, $urandom};

    cycles(2);
    reset = 1'b0;
    cycles(DEPTH + 2);

    send(1'b0, 14'd5, '0);
    cycles(1);

    send(1'b1, 14'h1234, 64'hDEADBEEFCAFEF00D);
    send(1'b0, 14'h1234, '0);
    cycles(2);

    for (int i = 1; i <= 4; i++) send(1'b1, 14'(i), 64'(i * 'h11));
    for (int i = 1; i <= 4; i++) send(1'b0, 14'(i), '0);
    cycles(2);

    bus.io_resp_ready = 1'b0;
    fork
      begin
        send(1'b0, 14'd1, '0);
        send(1'b0, 14'd2, '0);
        send(1'b0, 14'd3, '0);
      end
      begin
        cycles(7);
        bus.io_resp_ready = 1'b1;
      end
    join
    cycles(3);

    bus.io_resp_ready = 1'b0;
    send(1'b0, 14'd1, '0);
    send(1'b0, 14'd2, '0);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(DEPTH + 2);
    bus.io_resp_ready = 1'b1;

    for (int i = 0; i < 600; i++) begin
      bus.io_req_valid      = ($urandom_range(0, 9) < 7);
      bus.io_req_bits_write = $urandom_range(0, 1) == 1;
      bus.io_req_bits_addr  = 14'($urandom_range(0, 23));
      bus.io_req_bits_wdata = {$urandom, $urandom};
      bus.io_resp_ready     = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
    bus.io_req_valid  = 1'b0;
    bus.io_resp_ready = 1'b1;
    cycles(4);
    check("drain_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
